// File: rtl/dual_port_ram_pkg.sv
// Shared constants, clear-FSM state type and lane-merge helper for the byte-enabled dual-port RAM.
package dual_port_ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_WIDTH = 256;

    typedef logic [MAX_WIDTH-1:0] wide_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    // Masks are bit-expanded lane enables; port A wins where both masks are set.
    function automatic wide_word_t merge_word(
        input wide_word_t old_word,
        input wide_word_t data_a,
        input wide_word_t data_b,
        input wide_word_t mask_a,
        input wide_word_t mask_b
    );
        return (data_a & mask_a)
             | (data_b & mask_b & ~mask_a)
             | (old_word & ~(mask_a | mask_b));
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address writing zero, holding busy high meanwhile.
module ram_clear_seq
    import dual_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clear_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= addr_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        addr_next  = clr_addr;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we    = 1'b1;
                addr_next = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-lane write enables, collision merge, selectable read-during-write
// behaviour, optional output register and a post-reset clear sequence.
module dual_port_ram_be
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 18,
    parameter int ADDR_WIDTH     = 4,
    parameter int BYTE_WIDTH     = 9,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            address_a,
    input  logic [ADDR_WIDTH-1:0]            address_b,
    input  logic [DATA_WIDTH-1:0]            data_a,
    input  logic [DATA_WIDTH-1:0]            data_b,
    input  logic                             wren_a,
    input  logic                             wren_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteen_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteen_b,
    input  logic                             rden_a,
    input  logic                             rden_b,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             valid_a,
    output logic                             valid_b,
    output logic                             collision,
    output logic                             busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  active, same_addr, rd_en_a, rd_en_b, collision_now;
    logic [DATA_WIDTH-1:0] mask_a, mask_b, new_word_a, new_word_b;
    logic [DATA_WIDTH-1:0] q1_a, q1_b;
    logic                  v1_a, v1_b, coll1;

    // NOTE: the array has no reset; zeroing is done by the clear sequencer one word per cycle.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clock    (clock),
        .reset_n  (reset_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign active    = reset_n & ~busy;
    assign same_addr = (address_a == address_b);
    assign rd_en_a   = active & rden_a;
    assign rd_en_b   = active & rden_b;

    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            mask_a[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{active & wren_a & byteen_a[i]}};
            mask_b[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{active & wren_b & byteen_b[i]}};
        end
    end

    // Post-write word seen at each port's address; identical for both ports on a shared address.
    assign new_word_a = DATA_WIDTH'(merge_word(wide_word_t'(mem[address_a]),
        wide_word_t'(data_a), wide_word_t'(data_b),
        wide_word_t'(mask_a), wide_word_t'(same_addr ? mask_b : '0)));
    assign new_word_b = DATA_WIDTH'(merge_word(wide_word_t'(mem[address_b]),
        wide_word_t'(data_a), wide_word_t'(data_b),
        wide_word_t'(same_addr ? mask_a : '0), wide_word_t'(mask_b)));

    assign collision_now = same_addr & (|(mask_a & mask_b));

    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else begin
                if (|mask_a) begin
                    mem[address_a] <= new_word_a;
                end
                if ((|mask_b) && !(same_addr && (|mask_a))) begin
                    mem[address_b] <= new_word_b;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q1_a  <= '0;
            q1_b  <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            coll1 <= 1'b0;
        end else begin
            v1_a  <= rd_en_a;
            v1_b  <= rd_en_b;
            coll1 <= collision_now;
            if (rd_en_a) begin
                q1_a <= (READ_MODE == WRITE_FIRST) ? new_word_a : mem[address_a];
            end
            if (rd_en_b) begin
                q1_b <= (READ_MODE == WRITE_FIRST) ? new_word_b : mem[address_b];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] q2_a, q2_b;
            logic                  v2_a, v2_b, coll2;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    q2_a  <= '0;
                    q2_b  <= '0;
                    v2_a  <= 1'b0;
                    v2_b  <= 1'b0;
                    coll2 <= 1'b0;
                end else begin
                    v2_a  <= v1_a;
                    v2_b  <= v1_b;
                    coll2 <= coll1;
                    if (v1_a) begin
                        q2_a <= q1_a;
                    end
                    if (v1_b) begin
                        q2_b <= q1_b;
                    end
                end
            end

            assign q_a       = q2_a;
            assign q_b       = q2_b;
            assign valid_a   = v2_a;
            assign valid_b   = v2_b;
            assign collision = coll2;
        end else begin : g_no_out_reg
            assign q_a       = q1_a;
            assign q_b       = q1_b;
            assign valid_a   = v1_a;
            assign valid_b   = v1_b;
            assign collision = coll1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: three RAM variants share stimulus (read-first, write-first, output-registered).
module tb_dual_port_ram_be;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  address_a, address_b;
    logic [17:0] data_a, data_b;
    logic        wren_a, wren_b, rden_a, rden_b;
    logic [1:0]  byteen_a, byteen_b;

    logic [17:0] rf_q_a, rf_q_b, wf_q_a, wf_q_b, or_q_a, or_q_b;
    logic        rf_valid_a, rf_valid_b, wf_valid_a, wf_valid_b, or_valid_a, or_valid_b;
    logic        rf_collision, wf_collision, or_collision;
    logic        rf_busy, wf_busy, or_busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dual_port_ram_be #(.READ_MODE(0), .OUT_REG(0)) u_rf (
        .clock(clock), .reset_n(reset_n),
        .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
        .wren_a(wren_a), .wren_b(wren_b), .byteen_a(byteen_a), .byteen_b(byteen_b),
        .rden_a(rden_a), .rden_b(rden_b), .q_a(rf_q_a), .q_b(rf_q_b),
        .valid_a(rf_valid_a), .valid_b(rf_valid_b), .collision(rf_collision), .busy(rf_busy)
    );

    dual_port_ram_be #(.READ_MODE(1), .OUT_REG(0)) u_wf (
        .clock(clock), .reset_n(reset_n),
        .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
        .wren_a(wren_a), .wren_b(wren_b), .byteen_a(byteen_a), .byteen_b(byteen_b),
        .rden_a(rden_a), .rden_b(rden_b), .q_a(wf_q_a), .q_b(wf_q_b),
        .valid_a(wf_valid_a), .valid_b(wf_valid_b), .collision(wf_collision), .busy(wf_busy)
    );

    dual_port_ram_be #(.READ_MODE(0), .OUT_REG(1)) u_or (
        .clock(clock), .reset_n(reset_n),
        .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
        .wren_a(wren_a), .wren_b(wren_b), .byteen_a(byteen_a), .byteen_b(byteen_b),
        .rden_a(rden_a), .rden_b(rden_b), .q_a(or_q_a), .q_b(or_q_b),
        .valid_a(or_valid_a), .valid_b(or_valid_b), .collision(or_collision), .busy(or_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        byteen_a = 2'b00; byteen_b = 2'b00;
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [17:0] data, input logic [1:0] be);
        address_a = addr; data_a = data; byteen_a = be; wren_a = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic read_a(input logic [3:0] addr, input logic [17:0] exp, input string tag);
        address_a = addr; rden_a = 1'b1;
        tick();
        check({tag, "_rf_q_a"}, rf_q_a, exp);
        check({tag, "_rf_valid_a"}, rf_valid_a, 1);
        check({tag, "_wf_q_a"}, wf_q_a, exp);
        check({tag, "_or_valid_a_early"}, or_valid_a, 0);
        rden_a = 1'b0;
        tick();
        check({tag, "_or_q_a"}, or_q_a, exp);
        check({tag, "_or_valid_a"}, or_valid_a, 1);
        check({tag, "_rf_valid_a_drop"}, rf_valid_a, 0);
    endtask

    task automatic read_b(input logic [3:0] addr, input logic [17:0] exp, input string tag);
        address_b = addr; rden_b = 1'b1;
        tick();
        check({tag, "_rf_q_b"}, rf_q_b, exp);
        check({tag, "_rf_valid_b"}, rf_valid_b, 1);
        check({tag, "_wf_q_b"}, wf_q_b, exp);
        rden_b = 1'b0;
        tick();
        check({tag, "_or_q_b"}, or_q_b, exp);
        check({tag, "_or_valid_b"}, or_valid_b, 1);
    endtask

    initial begin
        int cnt;
        logic bad;

        reset_n = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        check("rst_rf_busy", rf_busy, 1);
        check("rst_or_busy", or_busy, 1);
        check("rst_rf_q_a", rf_q_a, 0);
        check("rst_or_q_b", or_q_b, 0);
        check("rst_rf_valid_a", rf_valid_a, 0);
        check("rst_or_valid_b", or_valid_b, 0);
        check("rst_rf_collision", rf_collision, 0);

        // Clear sequence lasts exactly 16 cycles
        reset_n = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (rf_busy && cnt < 40);
        check("clear_len", cnt, 16);
        check("clear_or_busy", or_busy, 0);

        for (int i = 0; i < 16; i++) begin
            read_a(4'(i), 18'h0, $sformatf("clr%0d", i));
        end

        // Partial-lane write
        write_a(4'd5, 18'h3FFFF, 2'b01);
        read_b(4'd5, 18'h001FF, "lane0");

        // Full overlap collision: A wins
        address_a = 4'd7; data_a = 18'h12345; byteen_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd7; data_b = 18'h3FFFF; byteen_b = 2'b10; wren_b = 1'b1;
        tick();
        idle_inputs();
        check("coll1_rf", rf_collision, 1);
        check("coll1_wf", wf_collision, 1);
        check("coll1_or_early", or_collision, 0);
        tick();
        check("coll1_rf_drop", rf_collision, 0);
        check("coll1_or", or_collision, 1);
        read_a(4'd7, 18'h12345, "coll1_data");

        // Disjoint lanes at one address: merge, no collision
        address_a = 4'd7; data_a = 18'h12345; byteen_a = 2'b01; wren_a = 1'b1;
        address_b = 4'd7; data_b = 18'h3FFFF; byteen_b = 2'b10; wren_b = 1'b1;
        tick();
        idle_inputs();
        check("coll2_rf", rf_collision, 0);
        tick();
        check("coll2_or", or_collision, 0);
        read_a(4'd7, 18'h3FF45, "coll2_data");

        // Different addresses written together
        address_a = 4'd8; data_a = 18'h11111; byteen_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd9; data_b = 18'h22222; byteen_b = 2'b11; wren_b = 1'b1;
        tick();
        idle_inputs();
        check("diff_rf_coll", rf_collision, 0);
        read_a(4'd8, 18'h11111, "diff_a");
        read_b(4'd9, 18'h22222, "diff_b");

        // Cross-port read during write
        write_a(4'd3, 18'h00AAA, 2'b11);
        address_a = 4'd3; data_a = 18'h00555; byteen_a = 2'b11; wren_a = 1'b1;
        address_b = 4'd3; rden_b = 1'b1;
        tick();
        idle_inputs();
        check("rdw_rf_q_b", rf_q_b, 18'h00AAA);
        check("rdw_wf_q_b", wf_q_b, 18'h00555);
        tick();
        check("rdw_or_q_b", or_q_b, 18'h00AAA);
        read_b(4'd3, 18'h00555, "rdw_after");

        // Output-register latency and hold
        write_a(4'd2, 18'h00042, 2'b11);
        address_a = 4'd2; rden_a = 1'b1;
        tick();
        rden_a = 1'b0;
        check("oreg_valid_n", or_valid_a, 0);
        tick();
        check("oreg_valid_n1", or_valid_a, 1);
        check("oreg_q_n1", or_q_a, 18'h00042);
        tick();
        check("oreg_valid_drop", or_valid_a, 0);
        check("oreg_q_hold", or_q_a, 18'h00042);

        // Write with no lanes enabled changes nothing
        write_a(4'd2, 18'h3FFFF, 2'b00);
        read_a(4'd2, 18'h00042, "be_zero");

        // Reset mid-clear restarts the full sequence; requests during busy are ignored
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_busy", rf_busy, 1);
        check("midrst_valid", rf_valid_a, 0);
        reset_n = 1'b1;
        address_a = 4'd0; data_a = 18'h3FFFF; byteen_a = 2'b11; wren_a = 1'b1; rden_a = 1'b1;
        address_b = 4'd0; data_b = 18'h3FFFF; byteen_b = 2'b11; wren_b = 1'b1; rden_b = 1'b1;
        cnt = 0;
        bad = 1'b0;
        do begin
            tick();
            cnt++;
            bad |= rf_valid_a | rf_valid_b | rf_collision | wf_valid_a | or_valid_a | or_collision;
        end while (rf_busy && cnt < 40);
        idle_inputs();
        check("midrst_len", cnt, 16);
        check("busy_ignored", bad, 0);
        read_a(4'd0, 18'h0, "busy_no_write");
        read_b(4'd9, 18'h0, "reclear9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
